// File: rtl/onembus_pkg.sv
// onembus_pkg: shared FSM state, page encodings and default E-clock timing.
package onembus_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, ACTIVE = 2'd2} state_t;
  localparam logic PAGE_FC = 1'b0;
  localparam logic PAGE_FD = 1'b1;
  localparam int CLK_DIV_DEF = 50;
  localparam int E_HIGH_DEF = 25;
  localparam int WDATA_START_DEF = 20;
endpackage

// File: rtl/onembus_ediv.sv
// onembus_ediv: free-running 1MHz E-clock divider with period-phase strobes.
module onembus_ediv #(
  parameter int CLK_DIV = 50,
  parameter int E_HIGH = 25,
  parameter int WDATA_START = 20
) (
  input  logic clk50,
  input  logic rst_n,
  output logic clke,
  output logic cnt0,
  output logic cnt1,
  output logic cnt_wd,
  output logic last
);
  localparam int CW = $clog2(CLK_DIV);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk50)
    if (!rst_n) cnt <= '0;
    else cnt <= last ? '0 : cnt + CW'(1);
  assign clke = cnt >= CW'(CLK_DIV - E_HIGH);
  assign cnt0 = cnt == '0;
  assign cnt1 = cnt == CW'(1);
  assign cnt_wd = cnt == CW'(WDATA_START);
  assign last = cnt == CW'(CLK_DIV - 1);
endmodule

// File: rtl/onembus_host.sv
// onembus_host: 1MHz bus host, one E period per access, &FC/&FD page strobes.
// Optional ONEMBUS_STATS_EN adds saturating rd_count/wr_count outputs.
module onembus_host import onembus_pkg::*; #(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int E_HIGH = E_HIGH_DEF,
  parameter int WDATA_START = WDATA_START_DEF
) (
  input  logic       clk50,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rnw,
  input  logic       cmd_page,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       clke,
  output logic       rnw,
  output logic       pgfc_n,
  output logic       pgfd_n,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_data_out,
  output logic       bus_data_oe,
  input  logic [7:0] bus_data_in
`ifdef ONEMBUS_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);
  state_t state;
  logic run, c_rnw, c_page, oe_q;
  logic [7:0] c_addr, c_wdata;
  logic cnt0, cnt1, cnt_wd, last;
  logic accept, go, done, n_rnw, n_page;
  logic [7:0] n_addr, n_wdata;

  onembus_ediv #(.CLK_DIV(CLK_DIV), .E_HIGH(E_HIGH), .WDATA_START(WDATA_START)) u_ediv (
    .clk50(clk50), .rst_n(rst_n), .clke(clke),
    .cnt0(cnt0), .cnt1(cnt1), .cnt_wd(cnt_wd), .last(last)
  );

  assign accept = cmd_valid && cmd_ready;
  // a command accepted in the cnt==0 cycle starts straight away, skipping ARMED
  assign go = cnt0 && (accept || state == ARMED);
  assign done = state == ACTIVE && last;
  assign n_rnw = accept ? cmd_rnw : c_rnw;
  assign n_page = accept ? cmd_page : c_page;
  assign n_addr = accept ? cmd_addr : c_addr;
  assign n_wdata = accept ? cmd_wdata : c_wdata;
  assign cmd_ready = run && state == IDLE;
  // oe_q covers WDATA_START+1 through the cnt==0 hold; masked once the next period begins
  assign bus_data_oe = !(pgfc_n && pgfd_n) && !rnw && (cnt_wd || (oe_q && !cnt1));

  always_ff @(posedge clk50)
    if (!rst_n) begin
      run <= 1'b0;
      state <= IDLE;
      {c_rnw, c_page, c_addr, c_wdata} <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rnw <= 1'b1;
      pgfc_n <= 1'b1;
      pgfd_n <= 1'b1;
      bus_addr <= '0;
      bus_data_out <= '0;
      oe_q <= 1'b0;
    end else begin
      run <= 1'b1;
      if (accept) {c_rnw, c_page, c_addr, c_wdata} <= {cmd_rnw, cmd_page, cmd_addr, cmd_wdata};
      state <= accept ? (cnt0 ? ACTIVE : ARMED) : go ? ACTIVE : done ? IDLE : state;
      rsp_valid <= done;
      if (done && c_rnw) rsp_rdata <= bus_data_in;
      if (go) begin
        rnw <= n_rnw;
        bus_addr <= n_addr;
        bus_data_out <= n_wdata;
        pgfc_n <= n_page != PAGE_FC;
        pgfd_n <= n_page != PAGE_FD;
      end else if (cnt0) begin
        rnw <= 1'b1;
        bus_addr <= '0;
        pgfc_n <= 1'b1;
        pgfd_n <= 1'b1;
      end
      oe_q <= cnt_wd ? 1'b1 : cnt1 ? 1'b0 : oe_q;
    end

`ifdef ONEMBUS_STATS_EN
  always_ff @(posedge clk50)
    if (!rst_n) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (done) begin
      if (c_rnw && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      if (!c_rnw && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_onembus_host.sv
// tb_onembus_host: random transactions vs. a period-level bus model and response scoreboard.
module tb_onembus_host;
  localparam int CLK_DIV = 50;
  localparam int E_HIGH = 25;
  localparam int WDATA_START = 20;

  typedef struct packed {logic rnw; logic page; logic [7:0] addr; logic [7:0] wdata;} cmd_t;
  typedef struct packed {logic rnw; logic [7:0] data;} rsp_t;

  logic clk50 = 1'b0, rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_rnw = 1'b1, cmd_page = 1'b0;
  logic [7:0] cmd_addr = '0, cmd_wdata = '0;
  logic cmd_ready, rsp_valid, clke, rnw, pgfc_n, pgfd_n, bus_data_oe;
  logic [7:0] rsp_rdata, bus_addr, bus_data_out, bus_data_in;
`ifdef ONEMBUS_STATS_EN
  logic [15:0] rd_count, wr_count;
`endif

  onembus_host dut (
    .clk50(clk50), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rnw(cmd_rnw), .cmd_page(cmd_page), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .clke(clke), .rnw(rnw),
    .pgfc_n(pgfc_n), .pgfd_n(pgfd_n), .bus_addr(bus_addr), .bus_data_out(bus_data_out),
    .bus_data_oe(bus_data_oe), .bus_data_in(bus_data_in)
`ifdef ONEMBUS_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );

  always #5 clk50 = ~clk50;

  cmd_t cmdq[$];
  rsp_t rspq[$];
  cmd_t cur;
  rsp_t r;
  logic cur_valid = 1'b0, rst_done = 1'b0, prev_rst = 1'b0, clke_prev = 1'b0, exp_oe, exp_ready;
  logic [7:0] rd_hold = '0;
  logic [7:0] dev [2][256];
  logic [7:0] ref_m [2][256];
  int phase = 0, n_chk = 0, n_fail = 0, rd_n = 0, wr_n = 0;

  // simple peripheral: drives read data while selected, latches writes on clke fall
  assign bus_data_in = !pgfc_n ? dev[0][bus_addr] : !pgfd_n ? dev[1][bus_addr] : 8'h00;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk50) begin
    if (rst_done) begin
      if (phase == 1) begin
        cur_valid = cmdq.size() > 0;
        if (cur_valid) cur = cmdq.pop_front();
      end
      exp_ready = prev_rst && cmdq.size() == 0 && !(cur_valid && phase != 0);
      exp_oe = cur_valid && !cur.rnw && (phase >= WDATA_START || phase == 0);
      chk("clke", clke, phase >= CLK_DIV - E_HIGH);
      chk("cmd_ready", cmd_ready, exp_ready);
      chk("pgfc_n", pgfc_n, !(cur_valid && cur.page == 1'b0));
      chk("pgfd_n", pgfd_n, !(cur_valid && cur.page == 1'b1));
      chk("rnw", rnw, cur_valid ? cur.rnw : 1'b1);
      chk("bus_addr", bus_addr, cur_valid ? cur.addr : 8'h00);
      chk("bus_data_oe", bus_data_oe, exp_oe);
      if (exp_oe) chk("bus_data_out", bus_data_out, cur.wdata);
      chk("rsp_valid", rsp_valid, cur_valid && phase == 0);
      if (rsp_valid) begin
        if (rspq.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          r = rspq.pop_front();
          if (r.rnw) begin rd_hold = r.data; rd_n++; end
          else wr_n++;
        end
      end
      chk("rsp_rdata", rsp_rdata, rd_hold);
    end
    if (clke_prev && !clke && bus_data_oe && !rnw) dev[pgfc_n][bus_addr] = bus_data_out;
    clke_prev = clke;
    if (!rst_n) begin
      rst_done = 1'b1;
      cmdq.delete();
      rspq.delete();
      cur_valid = 1'b0;
      rd_hold = '0;
      rd_n = 0;
      wr_n = 0;
    end
    prev_rst = rst_n;
    phase = rst_n ? (phase + 1) % CLK_DIV : 0;
  end

  task automatic issue(input logic rw, input logic pg, input logic [7:0] a, input logic [7:0] wd, input logic commit);
    int n = 0;
    logic ok = 1'b0;
    {cmd_rnw, cmd_page, cmd_addr, cmd_wdata} = {rw, pg, a, wd};
    cmd_valid = 1'b1;
    while (!ok && n < 400) begin
      @(negedge clk50);
      #1;
      ok = cmd_ready;
      n++;
    end
    if (!ok) chk("handshake_timeout", 0, 1);
    else begin
      cmdq.push_back({rw, pg, a, wd});
      rspq.push_back({rw, rw ? ref_m[pg][a] : 8'h00});
      if (!rw && commit) ref_m[pg][a] = wd;
    end
    @(posedge clk50);
    #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    int n;
    logic [7:0] v;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 256; i++) begin
        v = 8'($urandom);
        dev[p][i] = v;
        ref_m[p][i] = v;
      end
    dev[1][8'h12] = 8'hC5;
    ref_m[1][8'h12] = 8'hC5;
    repeat (5) @(posedge clk50);
    #1;
    rst_n = 1'b1;
    repeat (200) @(posedge clk50);
    #1;
    while (phase != 10) begin @(posedge clk50); #1; end
    issue(1'b0, 1'b0, 8'hFE, 8'h3A, 1'b1);
    issue(1'b1, 1'b1, 8'h12, 8'h00, 1'b1);
    issue(1'b1, 1'b0, 8'hFE, 8'h00, 1'b1);
    for (int k = 0; k < 4; k++) issue(1'b1, k[0], 8'(k * 3), 8'h00, 1'b1);
    for (int k = 0; k < 60; k++) begin
      repeat ($urandom_range(0, 60)) @(posedge clk50);
      #1;
      issue(1'($urandom), 1'($urandom), 8'($urandom_range(0, 7)), 8'($urandom), 1'b1);
    end
    issue(1'b0, 1'b0, 8'h40, 8'h99, 1'b0);
    n = 0;
    while ((phase != 30 || !cur_valid) && n < 200) begin @(posedge clk50); #1; n++; end
    if (n >= 200) chk("abort_wait_timeout", 0, 1);
    rst_n = 1'b0;
    repeat (3) @(posedge clk50);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk50);
    #1;
    issue(1'b1, 1'b0, 8'h40, 8'h00, 1'b1);
    for (int k = 0; k < 10; k++) begin
      repeat ($urandom_range(0, 20)) @(posedge clk50);
      #1;
      issue(1'($urandom), 1'($urandom), 8'($urandom_range(0, 3)), 8'($urandom), 1'b1);
    end
    n = 0;
    while ((cmdq.size() != 0 || rspq.size() != 0 || cur_valid) && n < 300) begin @(posedge clk50); #1; n++; end
    chk("drain_cmd", cmdq.size(), 0);
    chk("drain_rsp", rspq.size(), 0);
`ifdef ONEMBUS_STATS_EN
    chk("rd_count", rd_count, rd_n);
    chk("wr_count", wr_count, wr_n);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
